// File: rtl/alink_pkg.sv
// Shared definitions for the alink Wishbone master: register map, STATE
// register layout and the sequencer state encoding.
package alink_pkg;

  typedef enum logic [5:0] {
    ADR_TXFIFO = 6'h00,
    ADR_STATE  = 6'h04,
    ADR_MASK   = 6'h08,
    ADR_BUSY   = 6'h0c,
    ADR_RXFIFO = 6'h10
  } reg_adr_e;

  // STATE register layout: rxcnt 29:20, rxempty 16, txcnt 14:4, flush 1, txfull 0.
  typedef struct packed {
    logic [1:0]  rsvd_31_30;
    logic [9:0]  rxcnt;
    logic [2:0]  rsvd_19_17;
    logic        rxempty;
    logic        rsvd_15;
    logic [10:0] txcnt;
    logic [1:0]  rsvd_3_2;
    logic        flush;
    logic        txfull;
  } state_reg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DR_STAT,
    ST_DR_POP,
    ST_DR_OUT,
    ST_DR_END
  } state_e;

endpackage

// File: rtl/alink_wb_master_if.sv
// Wishbone bus between the alink master and the alink register slave.
interface alink_wb_master_if;
  logic        M_CYC_O;
  logic        M_STB_O;
  logic        M_WE_O;
  logic [5:0]  M_ADR_O;
  logic [31:0] M_DAT_O;
  logic [3:0]  M_SEL_O;
  logic        M_ACK_I;
  logic        M_ERR_I;
  logic        M_RTY_I;
  logic [31:0] M_DAT_I;

  modport master (
    output M_CYC_O, M_STB_O, M_WE_O, M_ADR_O, M_DAT_O, M_SEL_O,
    input  M_ACK_I, M_ERR_I, M_RTY_I, M_DAT_I
  );

  modport slave (
    input  M_CYC_O, M_STB_O, M_WE_O, M_ADR_O, M_DAT_O, M_SEL_O,
    output M_ACK_I, M_ERR_I, M_RTY_I, M_DAT_I
  );
endinterface

// File: rtl/alink_wb_xfer.sv
// Single Wishbone transfer engine: holds STB until ACK/ERR, forces one idle
// cycle afterwards, and aborts via watchdog when the slave never answers.
module alink_wb_xfer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    we,
  input  logic [5:0]              adr,
  input  logic [31:0]             wdata,
  output logic                    done,
  output logic                    err,
  output logic [31:0]             rdata,
  alink_wb_master_if.master       wb
);

  logic        stb_q;
  logic        we_q;
  logic [5:0]  adr_q;
  logic [31:0] dat_q;
  logic [7:0]  wdog;
  logic        term;
  logic        timeout;
  logic        unused_rty;

  assign term       = stb_q & (wb.M_ACK_I | wb.M_ERR_I);
  assign timeout    = stb_q & ~term & (wdog == 8'(TIMEOUT_CYC - 1));
  assign unused_rty = wb.M_RTY_I;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      wdog  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      done <= term | timeout;
      err  <= (stb_q & wb.M_ERR_I) | timeout;
      wdog <= (stb_q & ~term & ~timeout) ? wdog + 8'd1 : 8'd0;
      if (stb_q) begin
        if (term | timeout) begin
          // Dropping STB here guarantees the idle cycle before the next start.
          stb_q <= 1'b0;
          rdata <= (!we_q && wb.M_ACK_I && !wb.M_ERR_I && !timeout) ? wb.M_DAT_I : 32'd0;
        end
      end else if (start) begin
        stb_q <= 1'b1;
        we_q  <= we;
        adr_q <= adr;
        dat_q <= wdata;
      end
    end
  end

  assign wb.M_CYC_O = stb_q;
  assign wb.M_STB_O = stb_q;
  assign wb.M_WE_O  = we_q;
  assign wb.M_ADR_O = adr_q;
  assign wb.M_DAT_O = dat_q;
  assign wb.M_SEL_O = 4'hf;

endmodule

// File: rtl/alink_wb_master.sv
// alink Wishbone initiator: local single read/write commands plus an
// autonomous RX drain engine that streams RXFIFO words out with backpressure.
module alink_wb_master
  import alink_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int DRAIN_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  alink_wb_master_if.master  wb,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [5:0]         cmd_adr,
  input  logic [31:0]        cmd_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  input  logic               drain_start,
  input  logic [DRAIN_W-1:0] drain_max,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               drain_done,
  output logic [DRAIN_W-1:0] drain_cnt,
  output logic               drain_err,
  output logic               busy
);

  state_e             state, state_nxt;
  logic               x_start, x_we, x_done, x_err;
  logic [5:0]         x_adr;
  logic [31:0]        x_wdata, x_rdata;
  logic [DRAIN_W-1:0] max_q, target, target_calc, rxcnt, cnt_inc;
  state_reg_t         stat;

  alink_wb_xfer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_xfer (
    .clk   (clk),
    .rst   (rst),
    .start (x_start),
    .we    (x_we),
    .adr   (x_adr),
    .wdata (x_wdata),
    .done  (x_done),
    .err   (x_err),
    .rdata (x_rdata),
    .wb    (wb)
  );

  assign stat        = state_reg_t'(x_rdata);
  assign rxcnt       = DRAIN_W'(stat.rxcnt);
  assign target_calc = (max_q == '0) ? rxcnt : ((rxcnt < max_q) ? rxcnt : max_q);
  assign cnt_inc     = drain_cnt + DRAIN_W'(1);

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    x_start   = 1'b0;
    x_we      = 1'b0;
    x_adr     = ADR_STATE;
    x_wdata   = '0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = ST_CMD;
          x_start   = 1'b1;
          x_we      = cmd_we;
          x_adr     = cmd_adr;
          x_wdata   = cmd_wdata;
        end else if (drain_start) begin
          state_nxt = ST_DR_STAT;
          x_start   = 1'b1;
        end
      end
      ST_CMD: if (x_done) state_nxt = ST_IDLE;
      ST_DR_STAT: begin
        if (x_done) begin
          if (x_err || target_calc == '0) begin
            state_nxt = ST_DR_END;
          end else begin
            state_nxt = ST_DR_POP;
            x_start   = 1'b1;
            x_adr     = ADR_RXFIFO;
          end
        end
      end
      ST_DR_POP: if (x_done) state_nxt = x_err ? ST_DR_END : ST_DR_OUT;
      ST_DR_OUT: begin
        // Bus stays quiet while the consumer stalls; the next pop follows the handshake.
        if (out_ready) begin
          if (cnt_inc == target) begin
            state_nxt = ST_DR_END;
          end else begin
            state_nxt = ST_DR_POP;
            x_start   = 1'b1;
            x_adr     = ADR_RXFIFO;
          end
        end
      end
      ST_DR_END: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      max_q     <= '0;
      target    <= '0;
      drain_cnt <= '0;
      drain_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && !cmd_valid && drain_start) begin
        max_q     <= drain_max;
        drain_cnt <= '0;
        drain_err <= 1'b0;
      end
      if (state == ST_DR_STAT && x_done) target <= target_calc;
      if (state == ST_DR_OUT && out_ready) drain_cnt <= cnt_inc;
      if ((state == ST_DR_STAT || state == ST_DR_POP) && x_done && x_err) drain_err <= 1'b1;
    end
  end

  assign cmd_ready  = (state == ST_IDLE) && cmd_valid;
  assign rsp_valid  = (state == ST_CMD) && x_done;
  assign rsp_rdata  = rsp_valid ? x_rdata : 32'd0;
  assign rsp_err    = rsp_valid && x_err;
  assign out_valid  = (state == ST_DR_OUT);
  assign out_data   = out_valid ? x_rdata : 32'd0;
  assign drain_done = (state == ST_DR_END);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_alink_wb_master.sv
// Randomized bench for alink_wb_master: alink slave model on the bus, drain
// expectations computed from rxcnt/drain_max/error position.
module tb_alink_wb_master;
  import alink_pkg::*;

  localparam int TIMEOUT_CYC = 255;
  localparam int DRAIN_W     = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alink_wb_master_if wb ();

  logic               cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [5:0]         cmd_adr   = '0;
  logic [31:0]        cmd_wdata = '0;
  logic               cmd_ready, rsp_valid, rsp_err;
  logic [31:0]        rsp_rdata;
  logic               drain_start = 1'b0;
  logic [DRAIN_W-1:0] drain_max   = '0;
  logic               out_valid, out_ready = 1'b0;
  logic [31:0]        out_data;
  logic               drain_done, drain_err, busy;
  logic [DRAIN_W-1:0] drain_cnt;

  alink_wb_master #(.TIMEOUT_CYC(TIMEOUT_CYC), .DRAIN_W(DRAIN_W)) dut (
    .clk(clk), .rst(rst), .wb(wb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .drain_start(drain_start), .drain_max(drain_max), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drain_done(drain_done),
    .drain_cnt(drain_cnt), .drain_err(drain_err), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // alink register slave: ACK one cycle after STB, ERR on a chosen RXFIFO pop.
  logic        ack_r, err_r;
  logic [31:0] dat_r, mask_r;
  logic [31:0] busy_val      = 32'ha5a5_0001;
  logic        ack_en        = 1'b1;
  int          err_when_size = -1;
  logic [31:0] slv_q[$];

  function automatic logic [31:0] state_word(input int n);
    state_reg_t s;
    s         = '0;
    s.rxcnt   = 10'(n);
    s.rxempty = (n == 0);
    return s;
  endfunction

  assign wb.M_ACK_I = ack_r;
  assign wb.M_ERR_I = err_r;
  assign wb.M_RTY_I = 1'b0;
  assign wb.M_DAT_I = dat_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      dat_r  <= '0;
      mask_r <= '0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      dat_r <= '0;
      if (wb.M_STB_O && !ack_r && !err_r && ack_en) begin
        if (!wb.M_WE_O && wb.M_ADR_O == ADR_RXFIFO && slv_q.size() == err_when_size) begin
          err_r <= 1'b1;
        end else begin
          ack_r <= 1'b1;
          if (wb.M_WE_O) begin
            if (wb.M_ADR_O == ADR_MASK) mask_r <= wb.M_DAT_O;
          end else begin
            case (wb.M_ADR_O)
              ADR_STATE:  dat_r <= state_word(slv_q.size());
              ADR_MASK:   dat_r <= mask_r;
              ADR_BUSY:   dat_r <= busy_val;
              ADR_RXFIFO: if (slv_q.size() > 0) dat_r <= slv_q.pop_front();
              default:    dat_r <= '0;
            endcase
          end
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 4 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Bus / stream monitor, sampled on the falling edge.
  int          n_state_rd = 0, n_fifo_rd = 0, viol_stall = 0, viol_idle = 0, viol_stable = 0;
  int          stb_len = 0, last_len = 0, fall_cyc = 0, done_seen = 0;
  logic        stb_prev = 1'b0, ack_prev = 1'b0, last_we = 1'b0;
  logic [5:0]  adr_start = '0;
  logic [DRAIN_W-1:0] done_cnt = '0;
  logic        done_err = 1'b0;
  logic [31:0] got_q[$];

  always @(negedge clk) begin
    if (rst) begin
      stb_prev <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      if (wb.M_STB_O) begin
        if (!stb_prev) begin
          stb_len   <= 1;
          adr_start <= wb.M_ADR_O;
          last_we   <= wb.M_WE_O;
          if (!wb.M_WE_O && wb.M_ADR_O == ADR_STATE)  n_state_rd <= n_state_rd + 1;
          if (!wb.M_WE_O && wb.M_ADR_O == ADR_RXFIFO) n_fifo_rd  <= n_fifo_rd + 1;
        end else begin
          stb_len <= stb_len + 1;
          if (wb.M_ADR_O !== adr_start) viol_stable <= viol_stable + 1;
        end
        if (out_valid) viol_stall <= viol_stall + 1;
        if (ack_prev)  viol_idle  <= viol_idle + 1;
      end else if (stb_prev) begin
        last_len <= stb_len;
        fall_cyc <= cyc;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (drain_done) begin
        done_seen <= done_seen + 1;
        done_cnt  <= drain_cnt;
        done_err  <= drain_err;
      end
      ack_prev <= wb.M_STB_O && (wb.M_ACK_I || wb.M_ERR_I);
      stb_prev <= wb.M_STB_O;
    end
  end

  task automatic do_cmd(input logic we, input logic [5:0] adr, input logic [31:0] wd,
                        input int budget, output logic [31:0] rd, output logic er, output int lat);
    int  rsp_cyc;
    bit  got;
    got = 0; rd = '0; er = 1'b0; rsp_cyc = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_wdata = wd;
    @(negedge clk);
    check("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err; rsp_cyc = cyc; got = 1;
        break;
      end
    end
    if (!got) check("rsp_wait_expired", 0, 1);
    @(negedge clk);
    check("rsp_pulse_width", rsp_valid, 0);
    lat = rsp_cyc - fall_cyc;
  endtask

  task automatic do_drain(input int n, input int mx, input int mode, input int err_at, input bit seq);
    logic [31:0] words[$];
    int tgt, exp_cnt, exp_pops, s0, f0, v0, d0, g0;
    bit exp_err, seen;
    for (int i = 0; i < n; i++) words.push_back(seq ? 32'(32'h11 + i) : $urandom);
    tgt      = (mx == 0) ? n : ((n < mx) ? n : mx);
    exp_err  = (err_at >= 0) && (err_at < tgt);
    exp_cnt  = exp_err ? err_at : tgt;
    exp_pops = exp_err ? err_at + 1 : tgt;
    @(posedge clk); #1;
    slv_q = words;
    err_when_size = (err_at >= 0) ? n - err_at : -1;
    ready_mode = mode;
    s0 = n_state_rd; f0 = n_fifo_rd; v0 = viol_stall; d0 = done_seen; g0 = got_q.size();
    drain_max = DRAIN_W'(mx);
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (done_seen != d0) begin seen = 1; break; end
    end
    check("drain_done_seen", seen, 1);
    repeat (3) @(posedge clk);
    #1;
    check("drain_done_pulses", done_seen - d0, 1);
    check("drain_cnt_at_done", done_cnt, exp_cnt);
    check("drain_err_at_done", done_err, exp_err);
    check("drain_cnt_held", drain_cnt, exp_cnt);
    check("drain_idle", busy, 0);
    check("state_reads", n_state_rd - s0, 1);
    check("fifo_pops", n_fifo_rd - f0, exp_pops);
    check("pop_while_stalled", viol_stall - v0, 0);
    check("words_out", got_q.size() - g0, exp_cnt);
    for (int i = 0; i < exp_cnt && (g0 + i) < got_q.size(); i++)
      check($sformatf("word%0d", i), got_q[g0 + i], words[i]);
    err_when_size = -1;
    ready_mode = 0;
  endtask

  initial begin
    #900_000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rd, mdl_mask, wd;
    logic        er;
    int          lat, kind;
    mdl_mask = '0;

    repeat (3) @(negedge clk);
    check("rst_bus", {wb.M_STB_O, wb.M_CYC_O, wb.M_WE_O, wb.M_ADR_O, wb.M_DAT_O}, 0);
    check("rst_sel", wb.M_SEL_O, 4'hf);
    check("rst_ctl", {cmd_ready, rsp_valid, rsp_err, out_valid, drain_done, drain_err, busy, drain_cnt}, 0);
    check("rst_data", {rsp_rdata, out_data}, 0);
    rst = 1'b0;

    // Write MASK, then read back BUSY and MASK.
    do_cmd(1'b1, ADR_MASK, 32'h0000_00ff, 50, rd, er, lat);
    mdl_mask = 32'h0000_00ff;
    check("wr_err", er, 0);
    check("wr_rdata", rd, 0);
    check("wr_stb_len", last_len, 2);
    check("wr_we", last_we, 1);
    check("wr_mask_reg", mask_r, mdl_mask);
    do_cmd(1'b0, ADR_BUSY, 32'h0, 50, rd, er, lat);
    check("rd_busy", rd, busy_val);
    check("rd_busy_err", er, 0);
    check("rd_latency", lat, 0);
    do_cmd(1'b0, ADR_MASK, 32'h0, 50, rd, er, lat);
    check("rd_mask", rd, mdl_mask);

    do_drain(5, 0, 0, -1, 1'b1);
    do_drain(8, 3, 1, -1, 1'b0);
    do_drain(0, 0, 0, -1, 1'b0);
    do_drain(6, 0, 2, 2, 1'b0);

    for (int it = 0; it < 12; it++) begin
      int n, mx, ea;
      kind = $urandom_range(0, 2);
      wd   = $urandom;
      if (kind == 0) begin
        do_cmd(1'b1, ADR_MASK, wd, 50, rd, er, lat);
        mdl_mask = wd;
        check("rnd_wr_err", er, 0);
      end else if (kind == 1) begin
        do_cmd(1'b0, ADR_MASK, wd, 50, rd, er, lat);
        check("rnd_rd_mask", rd, mdl_mask);
      end else begin
        do_cmd(1'b0, ADR_TXFIFO, wd, 50, rd, er, lat);
        check("rnd_rd_tx", rd, 0);
      end
      n  = $urandom_range(0, 12);
      mx = $urandom_range(0, 15);
      ea = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
      do_drain(n, mx, $urandom_range(0, 2), ea, 1'b0);
    end
    check("stb_idle_after_ack", viol_idle, 0);
    check("bus_stable", viol_stable, 0);

    // Unresponsive slave: watchdog abort, then async reset in the middle of STB.
    ack_en = 1'b0;
    do_cmd(1'b0, ADR_BUSY, 32'h0, 400, rd, er, lat);
    check("to_err", er, 1);
    check("to_rdata", rd, 0);
    check("to_stb_len", last_len, TIMEOUT_CYC);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = ADR_BUSY;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("pre_rst_stb", wb.M_STB_O, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_stb", wb.M_STB_O, 0);
    check("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    mdl_mask = '0;
    do_cmd(1'b0, ADR_MASK, 32'h0, 50, rd, er, lat);
    check("post_rst_mask", rd, mdl_mask);
    do_drain(4, 0, 1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alink_wb_master.md
Name: alink_wb_master

Overview:
- Wishbone initiator that drives the alink register slave: STATE 0x04, MASK 0x08, BUSY 0x0c, RXFIFO 0x10, TXFIFO 0x00.
- Executes single read/write commands from a local controller.
- Autonomous drain engine reads STATE, extracts rxcnt, pops up to N words from RXFIFO and streams them out with backpressure.
- ACK timeout watchdog aborts hung transfers.

Parameters:
TIMEOUT_CYC, 255, cycles STB may wait for ACK/ERR before abort (8-bit counter)
DRAIN_W, 10, width of drain word count (matches rxcnt width)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
M_CYC_O  out  1  bus cycle, identical to M_STB_O
M_STB_O  out  1  strobe
M_WE_O  out  1  1=write
M_ADR_O  out  6  register address
M_DAT_O  out  32  write data
M_SEL_O  out  4  constant 4'hf
M_ACK_I  in  1  slave ack, one cycle after STB
M_ERR_I  in  1  slave error (terminates like ACK, flagged)
M_RTY_I  in  1  ignored
M_DAT_I  in  32  read data, valid in ACK cycle
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted this cycle
cmd_we  in  1  command direction
cmd_adr  in  6  command address
cmd_wdata  in  32  command write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  read data (0 for writes)
rsp_err  out  1  ERR or timeout on this command
drain_start  in  1  start drain (sampled in IDLE only)
drain_max  in  DRAIN_W  max words to pop; 0 = unlimited (use rxcnt)
out_valid  out  1  drained word valid
out_ready  in  1  consumer accept
out_data  out  32  drained word
drain_done  out  1  one-cycle pulse at drain end
drain_cnt  out  DRAIN_W  words delivered in last drain
drain_err  out  1  drain aborted (ERR/timeout), valid with drain_done
busy  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0, M_SEL_O=4'hf; FSM IDLE, counters 0. Reset mid-transfer drops STB immediately (async) and discards in-flight data.
- Bus rule: STB/CYC/WE/ADR/DAT registered and held stable until an ACK/ERR cycle. STB deasserts on the edge after ACK/ERR, giving at least one idle cycle between transfers (the slave re-acks held STB). Read data is captured in the ACK cycle. Minimum transfer = 2 cycles STB + 1 idle.
- Watchdog: counter runs while STB is high. When it reaches TIMEOUT_CYC without ACK/ERR, STB drops and the transfer is treated as ERR.
- States: IDLE, CMD, DR_STAT, DR_POP, DR_OUT, DR_END.
- IDLE:
  - cmd_valid -> cmd_ready=1 for one cycle, latch fields, go CMD.
  - Else drain_start -> DR_STAT.
  - cmd has priority if both are asserted. cmd_ready=0 outside IDLE.
- CMD: one transfer. On completion, rsp_valid pulse with rsp_rdata (read) and rsp_err. Return to IDLE.
- DR_STAT:
  - Read 0x04; rxcnt = M_DAT_I[29:20].
  - target = rxcnt if drain_max==0, else min(rxcnt, drain_max).
  - target==0 -> DR_END. Else DR_POP.
- DR_POP: read 0x10 (each read pops one word). Data goes to out_data with out_valid=1 -> DR_OUT.
- DR_OUT:
  - Hold out_valid/out_data until out_ready. No bus activity while stalled.
  - On handshake drain_cnt+1. If drain_cnt+1==target -> DR_END, else DR_POP.
- DR_END: drain_done pulse for 1 cycle -> IDLE. drain_cnt holds until the next drain_start.
- Error/timeout in any drain transfer: no out_valid for that word; drain_err=1; DR_END.
- rxcnt is sampled once per drain; words arriving later need a new drain_start.
- Arithmetic: target and drain_cnt are DRAIN_W bits unsigned. rxcnt max 1023 fits without wrap.

Decomposition:
- Shared package alink_pkg: register address constants (TXFIFO/STATE/MASK/BUSY/RXFIFO), STATE field positions (RXCNT 29:20, RXEMPTY 16, TXCNT 14:4, FLUSH 1, TXFULL 0), FSM state encoding.
- Sub-module alink_wb_xfer: single-transfer engine with STB hold, post-ACK idle cycle and watchdog. Interface: start/we/adr/wdata in, done/err/rdata out. Top-level FSM sequences it.

Test Plan:
1. cmd write 0x08 data 0x0000_00ff vs alink slave -> STB high 2 cycles, WE=1, reg_mask=0xff; rsp_valid with rsp_err=0; STB low ≥1 cycle after ACK.
2. cmd read 0x0c with busy=0xa5a5_0001 -> rsp_rdata=0xa5a5_0001 in the cycle after ACK.
3. Preload 5 RX words (0x11..0x15), drain_max=0, out_ready=1 -> one STATE read, 5 RXFIFO reads, out_data 0x11..0x15 in order, drain_done with drain_cnt=5, drain_err=0.
4. rxcnt=8, drain_max=3, out_ready toggled 1-of-4 cycles -> exactly 3 pops, no pop while out_valid stalled, drain_cnt=3.
5. rxcnt=0 -> single STATE read, drain_done next cycles with drain_cnt=0, no RXFIFO read.
6. Slave ACK tied 0, TIMEOUT_CYC=255 -> STB drops after 255 cycles, rsp_valid with rsp_err=1. Then assert rst mid-STB -> STB=0 and busy=0 immediately.
